gate_truth_checker: RTL and testbench
=====================================

# gate_truth_checker

Self-test sequencer that drives the two-input gate unit and checks its eight outputs against a golden model. On a `start` request it sweeps (a,b) through 00, 01, 10, 11 and waits a programmable settle time before each sample. It accumulates per-gate and per-vector mismatch flags and reports pass/fail with a one-cycle `done` pulse. It sits on the stimulus side of the gate unit, in bring-up and built-in-self-test wrappers.

## Interface
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling. Legal range is 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request, sampled only in IDLE.
- `gate_out`  in  8  outputs of the gate unit under test, in bit order [0]OR [1]AND [2]NOR [3]NAND [4]NOT [5]XOR [6]XNOR [7]BUFFER.
- `drive_a`  out  1  stimulus a, registered.
- `drive_b`  out  1  stimulus b, registered.
- `busy`  out  1  high from the first SETTLE cycle through the final SAMPLE cycle.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  result of the last run; valid from `done` until the next accepted `start`.
- `err_mask`  out  8  sticky OR of per-gate mismatches for the last run.
- `fail_vec`  out  4  bit i set if vector i = {a,b} had any mismatch.

## Operation
- States:
  - IDLE: `start` moves to SETTLE. On the same edge, clear `err_mask`, `fail_vec`, `pass` and `idx`, and drive (a,b)=00.
  - SETTLE: hold the drive for SETTLE_CYCLES cycles using a 4-bit counter, then move to SAMPLE.
  - SAMPLE: compare `gate_out` against expected(idx) and OR the XOR into `err_mask`. If it is nonzero, set `fail_vec[idx]`.
    - If idx==3, move to DONE.
    - Otherwise increment idx, update the drive, and move to SETTLE.
  - DONE: `done`=1, `pass` = (`err_mask`==0 including the final sample's contribution), then move to IDLE.
- Drive mapping: `drive_a`=idx[1], `drive_b`=idx[0]. In IDLE and DONE, the drive returns to 00.
- Expected values:
  - OR=a|b, AND=a&b, NOR=~(a|b), NAND=~(a&b), XOR=a^b, XNOR=~(a^b).
  - NOT and BUFFER are single-input gates: NOT=~a, BUFFER=a.
- `start` in any state other than IDLE is ignored; there is no queuing.
- `start` held high continuously gives back-to-back runs separated by exactly one IDLE cycle.
- `err_mask`, `fail_vec` and `pass` hold their values through IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `drive_a`=`drive_b`=0, `busy`=0, `done`=0, `pass`=0, `err_mask`=0, `fail_vec`=0, idx=0, counter=0.
- Reset mid-run forces the reset values on the next edge, with no `done` pulse.
- Let the edge sampling `start` be E0.
  - Vector i is driven from E0+i·(S+1), where S=SETTLE_CYCLES.
  - Vector i is sampled in the cycle after edge E0+i·(S+1)+S.
  - `done` is high in the cycle after edge E0+4·(S+1). For S=1 that is 8 edges after E0.
- Total run latency is 4·(S+1)+1 cycles including DONE.
- `gate_out` is treated as combinational from `drive_a`/`drive_b`. Only the SAMPLE cycle value matters; glitches during SETTLE are ignored.

## Structure
- Package `gate_check_pkg`:
  - gate index localparams GATE_OR..GATE_BUFFER = 0..7;
  - state enum typedef {IDLE, SETTLE, SAMPLE, DONE};
  - function `expected_gates(a,b)` returning logic [7:0].
- Sub-module `gate_expect`: combinational golden model (a,b → 8-bit expected) wrapping the package function. It is instantiated once, fed by `drive_a`/`drive_b`.
- The top level contains the FSM, settle counter, idx register and accumulators.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs 0 and state IDLE; `gate_out`=8'hFF has no effect.
- **Correct gate unit, S=1:**
  - Pulse `start` → drive sequence 00,01,10,11, each held 2 cycles.
  - `busy` high for 8 cycles, then `done` pulse.
  - Result: `pass`=1, `err_mask`=8'h00, `fail_vec`=4'b0000.
- **OR output stuck at 0:** → `err_mask`=8'h01, `fail_vec`=4'b1110, `pass`=0.
- **`start` behaviour:**
  - Re-asserting `start` mid-run does not restart; `done` still arrives 8 cycles after the first `start`.
  - `start` held high → second run begins after one IDLE cycle and clears results on acceptance.
- **Reset mid-run:** assert `rst` during SAMPLE of idx 2 → next cycle `busy`=0, drive 00, `err_mask` 0, no `done`; a following `start` completes normally.
- **S=3 with a glitching unit:** `gate_out` is wrong only in the first settle cycle of each vector → `done` arrives 16 edges after E0 and `pass`=1.

Source files
------------

// File: rtl/gate_check_pkg.sv
// gate_check_pkg: shared gate bit indices, sequencer states and the golden gate function.
package gate_check_pkg;
    localparam int GATE_OR     = 0;
    localparam int GATE_AND    = 1;
    localparam int GATE_NOR    = 2;
    localparam int GATE_NAND   = 3;
    localparam int GATE_NOT    = 4;
    localparam int GATE_XOR    = 5;
    localparam int GATE_XNOR   = 6;
    localparam int GATE_BUFFER = 7;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    // NOT and BUFFER look only at a; b is deliberately ignored for them.
    function automatic logic [7:0] expected_gates(input logic a, input logic b);
        logic [7:0] g;
        g[GATE_OR]     = a | b;
        g[GATE_AND]    = a & b;
        g[GATE_NOR]    = ~(a | b);
        g[GATE_NAND]   = ~(a & b);
        g[GATE_NOT]    = ~a;
        g[GATE_XOR]    = a ^ b;
        g[GATE_XNOR]   = ~(a ^ b);
        g[GATE_BUFFER] = a;
        return g;
    endfunction
endpackage

// File: rtl/gate_expect.sv
// gate_expect: combinational golden model of the two-input gate unit.
module gate_expect
    import gate_check_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [7:0] gates
);
    assign gates = expected_gates(a, b);
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps (a,b) over all four vectors, checks the gate unit, reports pass/fail.
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] gate_out,
    output logic       drive_a,
    output logic       drive_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_mask,
    output logic [3:0] fail_vec
);
    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic [7:0] expected;
    logic [7:0] diff;

    gate_expect u_expect (.a(drive_a), .b(drive_b), .gates(expected));

    assign diff = gate_out ^ expected;
    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            cnt      <= 4'd0;
            drive_a  <= 1'b0;
            drive_b  <= 1'b0;
            pass     <= 1'b0;
            err_mask <= 8'h00;
            fail_vec <= 4'h0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= SETTLE;
                    idx      <= 2'd0;
                    cnt      <= 4'd0;
                    {drive_a, drive_b} <= 2'b00;
                    pass     <= 1'b0;
                    err_mask <= 8'h00;
                    fail_vec <= 4'h0;
                end
                SETTLE: begin
                    state <= (cnt == LAST) ? SAMPLE : SETTLE;
                    cnt   <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
                end
                SAMPLE: begin
                    err_mask <= err_mask | diff;
                    if (|diff) fail_vec[idx] <= 1'b1;
                    // pass folds in this final sample since err_mask updates on the same edge
                    if (idx == 2'd3) begin
                        state <= DONE;
                        pass  <= (err_mask | diff) == 8'h00;
                        {drive_a, drive_b} <= 2'b00;
                    end else begin
                        state <= SETTLE;
                        idx   <= idx + 2'd1;
                        {drive_a, drive_b} <= idx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: directed checks of the self-test sequencer for settle times 1 and 3.
module tb_gate_truth_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start1 = 1'b0, start3 = 1'b0, glitch3 = 1'b0;
    logic [1:0] mode1 = 2'd2;
    logic       da1, db1, busy1, done1, pass1;
    logic       da3, db3, busy3, done3, pass3;
    logic [7:0] err1, err3, g1, g3;
    logic [3:0] fv1, fv3;
    int n_run = 0, n_fail = 0;

    function automatic logic [7:0] model(input logic a, input logic b);
        return {a, ~(a ^ b), a ^ b, ~a, ~(a & b), ~(a | b), a & b, a | b};
    endfunction

    // mode1: 0 healthy, 1 OR stuck at 0, 2 all ones
    always_comb g1 = (mode1 == 2'd2) ? 8'hFF : (model(da1, db1) & ((mode1 == 2'd1) ? 8'hFE : 8'hFF));
    always_comb g3 = model(da3, db3) ^ {8{glitch3}};

    gate_truth_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_out(g1), .drive_a(da1), .drive_b(db1),
        .busy(busy1), .done(done1), .pass(pass1), .err_mask(err1), .fail_vec(fv1)
    );
    gate_truth_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .gate_out(g3), .drive_a(da3), .drive_b(db3),
        .busy(busy3), .done(done3), .pass(pass3), .err_mask(err3), .fail_vec(fv3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1(input string tag);
        check({tag, "_busy"}, busy1, 0);
        check({tag, "_done"}, done1, 0);
        check({tag, "_pass"}, pass1, 0);
        check({tag, "_err"}, err1, 0);
        check({tag, "_fv"}, fv1, 0);
        check({tag, "_drv"}, {da1, db1}, 0);
    endtask

    task automatic run1(input logic [7:0] e_err, input logic [3:0] e_fv, input logic e_pass);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("run_drv", {da1, db1}, k / 2);
            check("run_busy", busy1, 1);
            check("run_done", done1, 0);
            tick();
        end
        check("end_done", done1, 1);
        check("end_busy", busy1, 0);
        check("end_pass", pass1, e_pass);
        check("end_err", err1, e_err);
        check("end_fv", fv1, e_fv);
        check("end_drv", {da1, db1}, 0);
        tick();
        check("pulse_done", done1, 0);
        check("hold_pass", pass1, e_pass);
        check("hold_err", err1, e_err);
        check("hold_fv", fv1, e_fv);
    endtask

    task automatic run3(input int gpos, input logic [7:0] e_err, input logic [3:0] e_fv, input logic e_pass);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            glitch3 = (k % 4) == gpos;
            check("s3_drv", {da3, db3}, k / 4);
            check("s3_busy", busy3, 1);
            check("s3_done", done3, 0);
            tick();
        end
        glitch3 = 1'b0;
        check("s3_end_done", done3, 1);
        check("s3_pass", pass3, e_pass);
        check("s3_err", err3, e_err);
        check("s3_fv", fv3, e_fv);
        tick();
        check("s3_pulse", done3, 0);
    endtask

    initial begin
        tick();
        tick();
        idle1("rst");
        check("rst3_busy", busy3, 0);
        check("rst3_err", err3, 0);
        rst = 1'b0;
        tick();
        idle1("idle_ff");
        mode1 = 2'd0;

        run1(8'h00, 4'b0000, 1'b1);
        mode1 = 2'd1;
        run1(8'h01, 4'b1110, 1'b0);
        mode1 = 2'd0;

        // start re-asserted mid-run must not restart
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (3) tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("mid_drv", {da1, db1}, 2);
        check("mid_busy", busy1, 1);
        repeat (4) tick();
        check("mid_done", done1, 1);
        check("mid_pass", pass1, 1);

        // start held high: back-to-back runs one IDLE cycle apart
        tick();
        mode1 = 2'd1;
        start1 = 1'b1;
        tick();
        repeat (8) tick();
        check("held_done1", done1, 1);
        check("held_err1", err1, 8'h01);
        tick();
        mode1 = 2'd0;
        check("held_idle_busy", busy1, 0);
        check("held_idle_done", done1, 0);
        check("held_idle_err", err1, 8'h01);
        tick();
        start1 = 1'b0;
        check("held_busy2", busy1, 1);
        check("held_clr_err", err1, 0);
        check("held_clr_fv", fv1, 0);
        check("held_clr_pass", pass1, 0);
        repeat (7) tick();
        check("held_done1_early", done1, 0);
        tick();
        check("held_done2", done1, 1);
        check("held_pass2", pass1, 1);
        tick();

        // reset during SAMPLE of vector 2
        mode1 = 2'd1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (5) tick();
        check("pre_rst_err", err1, 8'h01);
        check("pre_rst_drv", {da1, db1}, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle1("midrst");
        for (int k = 0; k < 4; k++) begin
            check("midrst_nodone", done1, 0);
            tick();
        end
        mode1 = 2'd0;
        run1(8'h00, 4'b0000, 1'b1);

        run3(0, 8'h00, 4'b0000, 1'b1);
        run3(3, 8'hFF, 4'b1111, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
